// File: rtl/ym_reg_writer.sv
`default_nettype none
// ============================================================================
// Module      : ym_reg_writer
// Description : Buffers (register, value) pairs in a FIFO and replays each as
//               a two-phase YM2612 bus write (address, then data) with the
//               inter-write wait the chip requires. Optional status polling of
//               ym_dout[7] during WAIT is enabled by YM_REG_WRITER_BUSY_POLL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ym_reg_writer #(
  parameter int DEPTH       = 8,
  parameter int WR_PULSE    = 1,
  parameter int GAP         = 1,
  parameter int WAIT_CYCLES = 476
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cen,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 req_reg,
  input  logic [7:0]                 req_val,
  input  logic [7:0]                 ym_dout,
  output logic [7:0]                 ym_din,
  output logic                       ym_addr,
  output logic                       ym_cs_n,
  output logic                       ym_wr_n,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAX1 = (WR_PULSE > GAP) ? WR_PULSE : GAP;
  localparam int MAXC = (MAX1 > WAIT_CYCLES) ? MAX1 : WAIT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_WR  = 3'd1,
    S_A_GAP = 3'd2,
    S_D_WR  = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  // FIFO storage and pointers
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;
  logic [15:0]   head;

  // Sequencer state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    val_q, val_d;

  // Registered bus outputs
  logic [7:0]    din_q, din_d;
  logic          addr_q, addr_d;
  logic          cs_n_q, cs_n_d;
  logic          wr_n_q, wr_n_d;

`ifdef YM_REG_WRITER_BUSY_POLL_EN
  logic [2:0]    poll_cnt_q, poll_cnt_d;
  logic          busy_timeout_q, busy_timeout_d;
  logic          unused_dout;
  assign unused_dout = ^ym_dout[6:0];
`else
  logic          unused_dout;
  assign unused_dout = ^ym_dout;
`endif

  assign req_ready = (level_q != LW'(DEPTH));
  assign push      = req_valid & req_ready;
  assign pop       = cen & (state_q == S_IDLE) & (level_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Fullness is judged on the pre-pop level, so a pop never frees a slot
    // for a push in the same clock.
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_reg, req_val};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    val_d   = val_q;
`ifdef YM_REG_WRITER_BUSY_POLL_EN
    poll_cnt_d     = poll_cnt_q;
    busy_timeout_d = busy_timeout_q;
`endif
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) begin
            {reg_d, val_d} = head;
            cnt_d          = CW'(WR_PULSE);
            state_d        = S_A_WR;
          end
        end
        S_A_WR: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            cnt_d   = CW'(GAP);
            state_d = S_A_GAP;
          end
        end
        S_A_GAP: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            cnt_d   = CW'(WR_PULSE);
            state_d = S_D_WR;
          end
        end
        S_D_WR: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            cnt_d   = CW'(WAIT_CYCLES);
            state_d = S_WAIT;
`ifdef YM_REG_WRITER_BUSY_POLL_EN
            poll_cnt_d = 3'd0;
`endif
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q - CW'(1);
`ifdef YM_REG_WRITER_BUSY_POLL_EN
          if (poll_cnt_q != 3'd4) begin
            poll_cnt_d = poll_cnt_q + 3'd1;
          end
          // Status is trusted only once the chip has had time to raise busy.
          if (poll_cnt_q == 3'd4 && !ym_dout[7]) begin
            state_d = S_IDLE;
          end else if (cnt_q <= CW'(1)) begin
            state_d = S_IDLE;
            if (ym_dout[7]) begin
              busy_timeout_d = 1'b1;
            end
          end
`else
          if (cnt_q <= CW'(1)) begin
            state_d = S_IDLE;
          end
`endif
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Bus outputs are decoded from the current state and registered, so they
  // trail the state register by one cen-cycle.
  always_comb begin
    din_d  = din_q;
    addr_d = addr_q;
    cs_n_d = cs_n_q;
    wr_n_d = wr_n_q;
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          cs_n_d = 1'b1;
          wr_n_d = 1'b1;
          addr_d = 1'b0;
        end
        S_A_WR: begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
          addr_d = 1'b0;
          din_d  = reg_q;
        end
        S_A_GAP: begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b1;
          addr_d = 1'b0;
          din_d  = reg_q;
        end
        S_D_WR: begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
          addr_d = 1'b1;
          din_d  = val_q;
        end
        S_WAIT: begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b1;
          addr_d = 1'b0;
          din_d  = val_q;
        end
        default: begin
          cs_n_d = 1'b1;
          wr_n_d = 1'b1;
          addr_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reg_q    <= '0;
      val_q    <= '0;
      din_q    <= '0;
      addr_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
`ifdef YM_REG_WRITER_BUSY_POLL_EN
      poll_cnt_q     <= '0;
      busy_timeout_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      val_q    <= val_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
`ifdef YM_REG_WRITER_BUSY_POLL_EN
      poll_cnt_q     <= poll_cnt_d;
      busy_timeout_q <= busy_timeout_d;
`endif
    end
  end

  assign ym_din  = din_q;
  assign ym_addr = addr_q;
  assign ym_cs_n = cs_n_q;
  assign ym_wr_n = wr_n_q;
  assign level   = level_q;
  assign busy    = (state_q != S_IDLE) | (level_q != '0);

endmodule
`default_nettype wire
